// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - LSU state encoding and funct3 load/store codes
package riscv_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

endpackage

// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - LSU-to-memory bus bundle with master/slave views
interface riscv_lsu_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] baddr;
    logic [XLEN-1:0] bwdata;
    logic [7:0]      bstrb;
    logic            ack;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (output req, we, baddr, bwdata, bstrb, input ack, rdata, err);
    modport slave  (input req, we, baddr, bwdata, bstrb, output ack, rdata, err);
endinterface

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - load lane extract/extend and store strobe/shift
module riscv_lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      ld_funct3,
    input  logic [2:0]      ld_lane,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data,
    input  logic [1:0]      st_size,
    input  logic [2:0]      st_lane,
    input  logic [XLEN-1:0] wdata,
    output logic [7:0]      st_strb,
    output logic [XLEN-1:0] st_wdata
);
    logic [XLEN-1:0] lane_data;

    assign lane_data = rdata >> {ld_lane, 3'b000};

    // 011 and 111 both fall through to the full doubleword
    always_comb begin
        case (ld_funct3)
            F3_LB:   ld_data = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, lane_data[7:0]};
            F3_LH:   ld_data = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, lane_data[15:0]};
            F3_LW:   ld_data = {{(XLEN-32){lane_data[31]}}, lane_data[31:0]};
            F3_LWU:  ld_data = {{(XLEN-32){1'b0}}, lane_data[31:0]};
            default: ld_data = lane_data;
        endcase
    end

    always_comb begin
        case (st_size)
            SZ_B:    st_strb = 8'h01 << st_lane;
            SZ_H:    st_strb = 8'h03 << st_lane;
            SZ_W:    st_strb = 8'h0F << st_lane;
            default: st_strb = 8'hFF;
        endcase
    end

    assign st_wdata = wdata << {st_lane, 3'b000};
endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - single-outstanding load/store unit; RISCV_LSU_TIMEOUT_EN adds a bus timeout
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_riscv_lsu_clk,
    input  logic            i_riscv_lsu_rst_n,
    input  logic            i_riscv_lsu_memread,
    input  logic            i_riscv_lsu_memwrite,
    input  logic [2:0]      i_riscv_lsu_funct3,
    input  logic [XLEN-1:0] i_riscv_lsu_addr,
    input  logic [XLEN-1:0] i_riscv_lsu_wdata,
    input  logic            i_riscv_lsu_flush,
    output logic            o_riscv_lsu_stall,
    output logic [XLEN-1:0] o_riscv_lsu_memload,
    output logic            o_riscv_lsu_misaligned,
    output logic            o_riscv_lsu_accfault,
    output logic            o_riscv_lsu_req,
    output logic            o_riscv_lsu_we,
    output logic [XLEN-1:0] o_riscv_lsu_baddr,
    output logic [XLEN-1:0] o_riscv_lsu_bwdata,
    output logic [7:0]      o_riscv_lsu_bstrb,
    input  logic            i_riscv_lsu_ack,
    input  logic [XLEN-1:0] i_riscv_lsu_rdata,
    input  logic            i_riscv_lsu_err
);
    lsu_state_e      state_q, state_d;
    logic            req_q, we_q, accf_q, kill_q;
    logic [XLEN-1:0] baddr_q, bwdata_q, memload_q;
    logic [7:0]      bstrb_q;
    logic [2:0]      f3_q, lane_q;
    logic            access, mis_cond, start, killed, finish, timeout;
    logic [XLEN-1:0] ld_data, st_wdata;
    logic [7:0]      st_strb;

    riscv_lsu_align #(.XLEN(XLEN)) u_align (
        .ld_funct3 (f3_q),
        .ld_lane   (lane_q),
        .rdata     (i_riscv_lsu_rdata),
        .ld_data   (ld_data),
        .st_size   (i_riscv_lsu_funct3[1:0]),
        .st_lane   (i_riscv_lsu_addr[2:0]),
        .wdata     (i_riscv_lsu_wdata),
        .st_strb   (st_strb),
        .st_wdata  (st_wdata)
    );

    always_comb begin
        case (i_riscv_lsu_funct3[1:0])
            SZ_H:    mis_cond = i_riscv_lsu_addr[0];
            SZ_W:    mis_cond = |i_riscv_lsu_addr[1:0];
            SZ_D:    mis_cond = |i_riscv_lsu_addr[2:0];
            default: mis_cond = 1'b0;
        endcase
    end

    assign access = (state_q == LSU_IDLE) && (i_riscv_lsu_memread || i_riscv_lsu_memwrite)
                    && !i_riscv_lsu_flush;
    assign start  = access && !mis_cond;
    // A flush arriving in the same cycle as the ack still kills the result
    assign killed = kill_q || i_riscv_lsu_flush;
    assign finish = (state_q == LSU_BUSY) && (i_riscv_lsu_ack || timeout);

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q;

    assign timeout = (state_q == LSU_BUSY) && !i_riscv_lsu_ack
                     && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
        if (!i_riscv_lsu_rst_n)         tmo_q <= '0;
        else if (state_q == LSU_BUSY)   tmo_q <= tmo_q + 1'b1;
        else                            tmo_q <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d                = state_q;
        o_riscv_lsu_stall      = 1'b0;
        o_riscv_lsu_misaligned = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                o_riscv_lsu_misaligned = access && mis_cond;
                o_riscv_lsu_stall      = start;
                if (start) state_d = LSU_BUSY;
            end
            LSU_BUSY: begin
                o_riscv_lsu_stall = 1'b1;
                if (finish) state_d = killed ? LSU_IDLE : LSU_DONE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
        if (!i_riscv_lsu_rst_n) begin
            state_q   <= LSU_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            bwdata_q  <= '0;
            bstrb_q   <= '0;
            memload_q <= '0;
            accf_q    <= 1'b0;
            kill_q    <= 1'b0;
            f3_q      <= '0;
            lane_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                req_q    <= 1'b1;
                we_q     <= i_riscv_lsu_memwrite;
                baddr_q  <= {i_riscv_lsu_addr[XLEN-1:3], 3'b000};
                bstrb_q  <= st_strb;
                bwdata_q <= st_wdata;
                f3_q     <= i_riscv_lsu_funct3;
                lane_q   <= i_riscv_lsu_addr[2:0];
                kill_q   <= 1'b0;
            end
            if (state_q == LSU_BUSY && i_riscv_lsu_flush) kill_q <= 1'b1;
            if (finish) begin
                req_q  <= 1'b0;
                kill_q <= 1'b0;
                if (!killed) begin
                    accf_q <= i_riscv_lsu_ack ? i_riscv_lsu_err : 1'b1;
                    if (i_riscv_lsu_ack)
                        memload_q <= i_riscv_lsu_err ? '0 : ld_data;
                end
            end
            if (state_q == LSU_DONE) accf_q <= 1'b0;
        end
    end

    assign o_riscv_lsu_req      = req_q;
    assign o_riscv_lsu_we       = we_q;
    assign o_riscv_lsu_baddr    = baddr_q;
    assign o_riscv_lsu_bwdata   = bwdata_q;
    assign o_riscv_lsu_bstrb    = bstrb_q;
    assign o_riscv_lsu_memload  = memload_q;
    assign o_riscv_lsu_accfault = (state_q == LSU_DONE) && accf_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - randomized self-checking bench for riscv_lsu against a behavioural model
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0, wdata = 64'd0;
    logic        stall, misaligned, accfault;
    logic [63:0] memload;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] ml_model = 64'd0;

    riscv_lsu_if #(.XLEN(64)) bus ();

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
        .i_riscv_lsu_clk        (clk),
        .i_riscv_lsu_rst_n      (rst_n),
        .i_riscv_lsu_memread    (memread),
        .i_riscv_lsu_memwrite   (memwrite),
        .i_riscv_lsu_funct3     (funct3),
        .i_riscv_lsu_addr       (addr),
        .i_riscv_lsu_wdata      (wdata),
        .i_riscv_lsu_flush      (flush),
        .o_riscv_lsu_stall      (stall),
        .o_riscv_lsu_memload    (memload),
        .o_riscv_lsu_misaligned (misaligned),
        .o_riscv_lsu_accfault   (accfault),
        .o_riscv_lsu_req        (bus.req),
        .o_riscv_lsu_we         (bus.we),
        .o_riscv_lsu_baddr      (bus.baddr),
        .o_riscv_lsu_bwdata     (bus.bwdata),
        .o_riscv_lsu_bstrb      (bus.bstrb),
        .i_riscv_lsu_ack        (bus.ack),
        .i_riscv_lsu_rdata      (bus.rdata),
        .i_riscv_lsu_err        (bus.err)
    );

    // Pick the addressed field by shifting it to the top, then shift back arithmetically or logically
    function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] f3,
                                             input logic [2:0] a);
        int          w;
        logic [63:0] t;
        w = 8 * (1 << f3[1:0]);
        t = rd >> (8 * a);
        if (w == 64) return t;
        t = t << (64 - w);
        if (f3[2]) return t >> (64 - w);
        return $signed(t) >>> (64 - w);
    endfunction

    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rdv, input logic e,
                              input int ack_delay, input int flush_at);
        int          nb, m;
        logic        mis, killed;
        logic [63:0] exp_baddr, exp_bwdata;
        logic [7:0]  exp_strb;
        nb         = 1 << f3[1:0];
        mis        = (a % 64'(nb)) != 0;
        killed     = (flush_at >= 0) && (flush_at <= ack_delay);
        exp_baddr  = a & ~64'h7;
        exp_bwdata = wd << (8 * a[2:0]);
        m          = ((1 << nb) - 1) << a[2:0];
        exp_strb   = m[7:0];
        @(negedge clk);
        memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        checks++; if (misaligned !== mis) begin errors++; $display("FAIL %s misaligned: got %b want %b", name, misaligned, mis); end
        checks++; if (stall !== !mis) begin errors++; $display("FAIL %s idle stall: got %b want %b", name, stall, !mis); end
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
        #1;
        if (mis) begin
            checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL %s req after misaligned: got %b want 0", name, bus.req); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s stall after misaligned: got %b want 0", name, stall); end
            return;
        end
        for (int k = 0; k <= ack_delay; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL %s busy req[%0d]: got %b want 1", name, k, bus.req); end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s busy stall[%0d]: got %b want 1", name, k, stall); end
            checks++; if (bus.we !== wr) begin errors++; $display("FAIL %s we: got %b want %b", name, bus.we, wr); end
            checks++; if (bus.baddr !== exp_baddr) begin errors++; $display("FAIL %s baddr: got %h want %h", name, bus.baddr, exp_baddr); end
            if (wr) begin
                checks++; if (bus.bstrb !== exp_strb) begin errors++; $display("FAIL %s bstrb: got %h want %h", name, bus.bstrb, exp_strb); end
                checks++; if (bus.bwdata !== exp_bwdata) begin errors++; $display("FAIL %s bwdata: got %h want %h", name, bus.bwdata, exp_bwdata); end
            end
            flush = (k == flush_at);
            if (k == ack_delay) begin bus.ack = 1'b1; bus.rdata = rdv; bus.err = e; end
        end
        @(negedge clk);
        bus.ack = 1'b0; bus.err = 1'b0; flush = 1'b0;
        if (!killed) ml_model = e ? 64'd0 : ref_load(rdv, f3, a[2:0]);
        #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL %s req after ack: got %b want 0", name, bus.req); end
        checks++; if (memload !== ml_model) begin errors++; $display("FAIL %s memload: got %h want %h", name, memload, ml_model); end
        checks++; if (accfault !== (e && !killed)) begin errors++; $display("FAIL %s accfault: got %b want %b", name, accfault, e && !killed); end
        // Probe the state: IDLE answers a new aligned load with stall, DONE ignores it
        memread = 1'b1; funct3 = 3'b011; addr = 64'h0; #1;
        checks++; if (stall !== killed) begin errors++; $display("FAIL %s post-ack probe stall: got %b want %b", name, stall, killed); end
        memread = 1'b0; #1;
        @(negedge clk); #1;
        checks++; if (accfault !== 1'b0) begin errors++; $display("FAIL %s accfault width: got %b want 0", name, accfault); end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset req: got %b want 0", bus.req); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset we: got %b want 0", bus.we); end
        checks++; if (bus.baddr !== 64'd0) begin errors++; $display("FAIL reset baddr: got %h want 0", bus.baddr); end
        checks++; if (bus.bwdata !== 64'd0) begin errors++; $display("FAIL reset bwdata: got %h want 0", bus.bwdata); end
        checks++; if (bus.bstrb !== 8'd0) begin errors++; $display("FAIL reset bstrb: got %h want 0", bus.bstrb); end
        checks++; if (memload !== 64'd0) begin errors++; $display("FAIL reset memload: got %h want 0", memload); end
        checks++; if ({stall, misaligned, accfault} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {stall, misaligned, accfault}); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_access("lb_sign", 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h00000000_80000000, 1'b0, 0, -1);
        checks++; if (ml_model !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_sign model: got %h want ffffffffffffff80", ml_model); end
        run_access("sh_lane6", 1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 64'h0, 1'b0, 1, -1);
        run_access("lw_misaligned", 1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 64'h0, 1'b0, 0, -1);
        run_access("ld_err", 1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0, -1);
        run_access("lhu_ok", 1'b1, 1'b0, 3'b101, 64'h5002, 64'h0, 64'h1111_2222_8765_3333, 1'b0, 2, -1);
        run_access("ld_flush", 1'b1, 1'b0, 3'b011, 64'h6000, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0, 4, 1);
        run_access("both_is_store", 1'b1, 1'b1, 3'b010, 64'h7004, 64'h0102_0304, 64'h0, 1'b0, 0, -1);
        run_access("lx111_as_ld", 1'b1, 1'b0, 3'b111, 64'h8008, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0, 0, -1);
    endtask

    task automatic test_flush_idle;
        @(negedge clk);
        memread = 1'b1; funct3 = 3'b011; addr = 64'h9000; flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle stall: got %b want 0", stall); end
        @(negedge clk);
        memread = 1'b0; flush = 1'b0; #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL flush_idle req: got %b want 0", bus.req); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f3;
            logic [63:0] a;
            int          sel, nb, dly, fa;
            f3  = 3'($urandom_range(0, 7));
            a   = {$urandom, $urandom};
            nb  = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(nb) - 64'd1);
            sel = $urandom_range(0, 2);
            dly = $urandom_range(0, 3);
            fa  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, dly) : -1;
            run_access($sformatf("rand%0d", i), sel != 1, sel != 0, f3, a, {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom_range(0, 9) == 0, dly, fa);
        end
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        memread = 1'b1; funct3 = 3'b011; addr = 64'hA000;
        @(negedge clk);
        memread = 1'b0; #1;
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL reset_busy pre req: got %b want 1", bus.req); end
        rst_n = 1'b0; #1;
        ml_model = 64'd0;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_busy req: got %b want 0", bus.req); end
        checks++; if (memload !== 64'd0) begin errors++; $display("FAIL reset_busy memload: got %h want 0", memload); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if ({bus.req, stall} !== 2'b00) begin errors++; $display("FAIL reset_busy after: got %b want 00", {bus.req, stall}); end
    endtask

`ifdef RISCV_LSU_TIMEOUT_EN
    task automatic test_timeout;
        run_access("pre_timeout", 1'b1, 1'b0, 3'b100, 64'hB001, 64'h0, 64'h0000_0000_0000_5A00, 1'b0, 0, -1);
        @(negedge clk);
        memread = 1'b1; funct3 = 3'b011; addr = 64'hC000;
        @(negedge clk);
        memread = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL timeout req[%0d]: got %b want 1", k, bus.req); end
        end
        @(negedge clk); #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL timeout req drop: got %b want 0", bus.req); end
        checks++; if (accfault !== 1'b1) begin errors++; $display("FAIL timeout accfault: got %b want 1", accfault); end
        checks++; if (memload !== ml_model) begin errors++; $display("FAIL timeout memload: got %h want %h", memload, ml_model); end
        @(negedge clk); #1;
        checks++; if (accfault !== 1'b0) begin errors++; $display("FAIL timeout accfault width: got %b want 0", accfault); end
    endtask
`endif

    initial begin
        bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = 64'd0;
        test_reset();
        test_directed();
        test_flush_idle();
        test_random();
        test_reset_busy();
`ifdef RISCV_LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
